// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, constants and fetch FSM encoding for the MIPS pipeline
package mips_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: PC, instruction-memory, downstream-control and IF/ID signals of the fetch stage
interface if_fetch_ctrl_if;
  import mips_pipe_pkg::*;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_next;
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic stall_id;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  modport master (
    input pc_cur, imem_ready, imem_rdata, stall_id, redirect, redirect_pc,
    output pc_next, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4
  );
  modport slave (
    output pc_cur, imem_ready, imem_rdata, stall_id, redirect, redirect_pc,
    input pc_next, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4
  );
endinterface

// File: rtl/if_id_skid.sv
// if_id_skid: one-entry buffer catching a fetched word that ID could not accept
module if_id_skid
  import mips_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clr,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= INSTR_NOP;
      pc <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc <= d_pc;
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch sequencing, next-PC selection and IF/ID pipeline register
module if_fetch_ctrl
  import mips_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  if_fetch_ctrl_if.master bus
);
  logic [1:0] state;
  logic [XLEN-1:0] addr_q, pc_inc, skid_instr, skid_pc;
  logic skid_valid, skid_load, skid_clr, live, fetch, hold, drain, rdy, stall, redir;
  assign live = state != ST_INIT;
  assign fetch = state == ST_FETCH;
  assign hold = state == ST_HOLD;
  assign drain = state == ST_DRAIN;
  assign rdy = bus.imem_ready;
  assign stall = bus.stall_id;
  assign redir = live & bus.redirect;
  assign pc_inc = bus.pc_cur + PC_STEP;
  assign skid_load = !redir & fetch & rdy & stall;
  assign skid_clr = redir | hold & !stall;
  always_comb begin
    bus.imem_req = fetch | drain;
    bus.imem_addr = drain ? addr_q : bus.pc_cur;
    bus.pc_next = !live ? RESET_PC : redir ? bus.redirect_pc :
                  ((fetch & rdy | hold) & !stall) ? pc_inc : bus.pc_cur;
  end
  if_id_skid u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .clr(skid_clr),
    .d_instr(bus.imem_rdata), .d_pc(bus.pc_cur),
    .valid(skid_valid), .instr(skid_instr), .pc(skid_pc)
  );
  // addr_q tracks the outstanding address so DRAIN can keep presenting it after a redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      addr_q <= '0;
      bus.id_valid <= 1'b0;
      bus.id_instr <= INSTR_NOP;
      bus.id_pc <= '0;
      bus.id_pc4 <= '0;
    end else if (!live) begin
      state <= ST_FETCH;
    end else if (redir) begin
      bus.id_valid <= 1'b0;
      if (fetch) addr_q <= bus.pc_cur;
      state <= (bus.imem_req & !rdy) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (fetch) addr_q <= bus.pc_cur;
      if (fetch & rdy & !stall) begin
        bus.id_valid <= 1'b1;
        bus.id_instr <= bus.imem_rdata;
        bus.id_pc <= bus.pc_cur;
        bus.id_pc4 <= pc_inc;
      end else if (hold & !stall) begin
        bus.id_valid <= skid_valid;
        bus.id_instr <= skid_instr;
        bus.id_pc <= skid_pc;
        bus.id_pc4 <= skid_pc + PC_STEP;
      end else if ((fetch | drain) & !stall) begin
        bus.id_valid <= 1'b0;
      end
      state <= skid_load ? ST_HOLD : (hold & !stall | drain & rdy) ? ST_FETCH : state;
    end
endmodule
